// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the fetch PC and keeps at most one memory request in flight.
// Returned words sit in a one-entry output register with their PC and a static branch prediction.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_rdata,
  output logic [31:0] inst_pc,
  output logic        inst_predict_branch,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;

  logic        r_out_valid;
  logic [31:0] r_out_rdata;
  logic [31:0] r_out_pc;
  logic        r_out_pred;

  logic        w_issue;
  logic        w_load;
  logic        w_pred;
  logic [31:0] w_bimm;

  // Backward-taken / forward-not-taken: only conditional branches with a negative offset.
  always_comb begin
    w_pred = (imem_rdata[6:0] == 7'b1100011) && imem_rdata[31];
    w_bimm = {{20{imem_rdata[31]}}, imem_rdata[7], imem_rdata[30:25],
              imem_rdata[11:8], 1'b0};
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_issue      = 1'b0;
    w_load       = 1'b0;
    if (redirect_valid) begin
      w_pc_next = redirect_pc;
      case (r_state)
        ST_ISSUE: w_state_next = ST_ISSUE;
        ST_WAIT:  w_state_next = imem_resp ? ST_ISSUE : ST_DRAIN;
        // A response landing alongside the redirect still retires the stale request.
        ST_DRAIN: w_state_next = imem_resp ? ST_ISSUE : ST_DRAIN;
        default:  w_state_next = ST_ISSUE;
      endcase
    end else begin
      case (r_state)
        ST_ISSUE: begin
          if (!rst && (!r_out_valid || inst_ready)) begin
            w_issue      = 1'b1;
            w_state_next = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_resp) begin
            w_load       = 1'b1;
            w_pc_next    = w_pred ? (r_pc + w_bimm) : (r_pc + 32'd4);
            w_state_next = ST_ISSUE;
          end
        end
        ST_DRAIN: begin
          if (imem_resp) w_state_next = ST_ISSUE;
        end
        default: w_state_next = ST_ISSUE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_ISSUE;
      r_pc        <= RESET_PC;
      r_out_valid <= 1'b0;
      r_out_rdata <= 32'd0;
      r_out_pc    <= 32'd0;
      r_out_pred  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (redirect_valid) begin
        r_out_valid <= 1'b0;
      end else if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_rdata <= imem_rdata;
        r_out_pc    <= r_pc;
        r_out_pred  <= w_pred;
      end else if (r_out_valid && inst_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign imem_addr           = r_pc;
  assign imem_rmask          = w_issue ? 4'hf : 4'h0;
  assign inst_valid          = r_out_valid;
  assign inst_rdata          = r_out_rdata;
  assign inst_pc             = r_out_pc;
  assign inst_predict_branch = r_out_pred;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a vector table of fetched words plus hand-built
// sequences for backpressure, redirects and reset during an outstanding request.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h1eceb000;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_rdata;
  logic [31:0] inst_pc;
  logic        inst_predict_branch;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
    logic        pred;
    logic [31:0] next;
  } vec_t;

  vec_t vecs [7];

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .imem_addr           (imem_addr),
    .imem_rmask          (imem_rmask),
    .imem_rdata          (imem_rdata),
    .imem_resp           (imem_resp),
    .inst_valid          (inst_valid),
    .inst_ready          (inst_ready),
    .inst_rdata          (inst_rdata),
    .inst_pc             (inst_pc),
    .inst_predict_branch (inst_predict_branch),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Move to just after the next rising edge; inputs are changed here.
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Called in a settled cycle where a request is expected; serves it with latency k.
  task automatic fetch_one(input logic [31:0] exp_addr, input logic [31:0] word,
                           input int k, input logic exp_pred);
    chk("req_mask", {28'd0, imem_rmask}, 32'hf);
    chk("req_addr", imem_addr, exp_addr);
    for (int j = 1; j < k; j++) begin
      adv();
      settle();
      chk("wait_mask", {28'd0, imem_rmask}, 32'h0);
    end
    adv();
    imem_resp  = 1'b1;
    imem_rdata = word;
    settle();
    chk("resp_mask", {28'd0, imem_rmask}, 32'h0);
    adv();
    imem_resp  = 1'b0;
    imem_rdata = 32'hdeadbeef;
    settle();
    chk("out_valid", {31'd0, inst_valid}, 32'd1);
    chk("out_rdata", inst_rdata, word);
    chk("out_pc", inst_pc, exp_addr);
    chk("out_pred", {31'd0, inst_predict_branch}, {31'd0, exp_pred});
    $display("fetch pc=%h word=%h k=%0d pred=%0d valid=%0d", exp_addr, word, k,
             inst_predict_branch, inst_valid);
  endtask

  initial begin
    vecs[0] = '{pc: 32'h1eceb010, word: 32'hfe000ee3, pred: 1'b1, next: 32'h1eceb00c};
    vecs[1] = '{pc: 32'h1eceb010, word: 32'h00000463, pred: 1'b0, next: 32'h1eceb014};
    vecs[2] = '{pc: 32'h1eceb100, word: 32'hfe1ff06f, pred: 1'b0, next: 32'h1eceb104};
    vecs[3] = '{pc: 32'h1eceb200, word: 32'hfc0018e3, pred: 1'b1, next: 32'h1eceb1d0};
    vecs[4] = '{pc: 32'h1eceb400, word: 32'h7e000fe3, pred: 1'b0, next: 32'h1eceb404};
    vecs[5] = '{pc: 32'h00000000, word: 32'hfe000ee3, pred: 1'b1, next: 32'hfffffffc};
    vecs[6] = '{pc: 32'h1eceb300, word: 32'hfff00093, pred: 1'b0, next: 32'h1eceb304};

    rst            = 1'b1;
    imem_resp      = 1'b0;
    imem_rdata     = 32'hdeadbeef;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;

    adv();
    adv();
    settle();
    chk("rst_mask", {28'd0, imem_rmask}, 32'h0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_rdata", inst_rdata, 32'd0);
    chk("rst_pc", inst_pc, 32'd0);
    chk("rst_pred", {31'd0, inst_predict_branch}, 32'd0);

    // Straight-line fetch, k=2: requests in cycles 0, 3, 6.
    adv();
    rst = 1'b0;
    settle();
    for (int i = 0; i < 3; i++) begin
      fetch_one(RST_PC + 32'(4 * i), 32'h00100093 + 32'(i << 20), 2, 1'b0);
    end

    // Vector table: redirect to each PC, fetch one word, check prediction and next address.
    for (int v = 0; v < 7; v++) begin
      redirect_valid = 1'b1;
      redirect_pc    = vecs[v].pc;
      settle();
      chk("redir_mask", {28'd0, imem_rmask}, 32'h0);
      adv();
      redirect_valid = 1'b0;
      settle();
      fetch_one(vecs[v].pc, vecs[v].word, 2, vecs[v].pred);
      chk("next_addr", imem_addr, vecs[v].next);
      chk("next_mask", {28'd0, imem_rmask}, 32'hf);
    end

    // Backpressure for 5 cycles with the last table word held.
    inst_ready = 1'b0;
    settle();
    chk("bp_mask", {28'd0, imem_rmask}, 32'h0);
    for (int j = 0; j < 4; j++) begin
      adv();
      settle();
      chk("bp_mask", {28'd0, imem_rmask}, 32'h0);
      chk("bp_valid", {31'd0, inst_valid}, 32'd1);
      chk("bp_rdata", inst_rdata, vecs[6].word);
      chk("bp_pc", inst_pc, vecs[6].pc);
    end
    adv();
    inst_ready = 1'b1;
    settle();
    chk("bp_rel_mask", {28'd0, imem_rmask}, 32'hf);
    chk("bp_rel_addr", imem_addr, 32'h1eceb304);
    $display("backpressure released addr=%h", imem_addr);

    // Redirect while waiting; stale response arrives three cycles later.
    adv();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1eceb100;
    settle();
    chk("rw_mask", {28'd0, imem_rmask}, 32'h0);
    adv();
    redirect_valid = 1'b0;
    settle();
    chk("rw_drain_valid", {31'd0, inst_valid}, 32'd0);
    chk("rw_drain_mask", {28'd0, imem_rmask}, 32'h0);
    adv();
    settle();
    chk("rw_drain_mask", {28'd0, imem_rmask}, 32'h0);
    adv();
    imem_resp  = 1'b1;
    imem_rdata = 32'h0badf00d;
    settle();
    chk("rw_resp_mask", {28'd0, imem_rmask}, 32'h0);
    adv();
    imem_resp  = 1'b0;
    imem_rdata = 32'hdeadbeef;
    settle();
    chk("rw_valid", {31'd0, inst_valid}, 32'd0);
    chk("rw_mask", {28'd0, imem_rmask}, 32'hf);
    chk("rw_addr", imem_addr, 32'h1eceb100);
    $display("redirect in wait -> addr=%h", imem_addr);
    fetch_one(32'h1eceb100, 32'h00200113, 1, 1'b0);

    // Redirect coinciding with the response: the word is dropped.
    adv();
    imem_resp      = 1'b1;
    imem_rdata     = 32'h00300193;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1eceb500;
    settle();
    chk("rr_mask", {28'd0, imem_rmask}, 32'h0);
    adv();
    imem_resp      = 1'b0;
    imem_rdata     = 32'hdeadbeef;
    redirect_valid = 1'b0;
    settle();
    chk("rr_valid", {31'd0, inst_valid}, 32'd0);
    chk("rr_mask", {28'd0, imem_rmask}, 32'hf);
    chk("rr_addr", imem_addr, 32'h1eceb500);
    $display("redirect with resp -> addr=%h valid=%0d", imem_addr, inst_valid);

    // Reset while a request is outstanding.
    adv();
    rst = 1'b1;
    settle();
    adv();
    rst = 1'b0;
    settle();
    chk("rstw_mask", {28'd0, imem_rmask}, 32'hf);
    chk("rstw_addr", imem_addr, RST_PC);
    chk("rstw_valid", {31'd0, inst_valid}, 32'd0);
    fetch_one(RST_PC, 32'h00400213, 3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
